wb_ext_mem_responder: RTL
=========================

Name: wb_ext_mem_responder

Overview:
- Wishbone B3 slave that terminates the external memory bus driven by the debug memory-access module in the SoC core.
- Backs a word-organised on-chip RAM.
- Supports classic cycles and registered-feedback incrementing bursts (linear, wrap-4/8/16), with configurable wait states and an error response for out-of-range addresses.
- Used as the simulation/FPGA memory model behind the core's wb_ext_* port.

Parameters:
- ADDR_WIDTH, 27, byte-address width of wb_adr_i; matches $clog2 of a 128 MiB MEM_SIZE.
- DATA_WIDTH, 32, data width; only 32 is supported.
- MEM_WORDS, 4096, implemented depth in 32-bit words; word indices >= MEM_WORDS are out of range.
- WAIT_STATES, 0, extra cycles inserted before the first ack of each cycle or burst (0..15).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- wb_adr_i  in  ADDR_WIDTH  byte address; word index = adr[ADDR_WIDTH-1:2], bits [1:0] ignored
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte enables; bit n covers data[8n+7:8n]
- wb_we_i  in  1  write enable
- wb_cyc_i  in  1  bus cycle valid
- wb_stb_i  in  1  strobe
- wb_cti_i  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst; all other codes are treated as classic
- wb_bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16
- wb_dat_o  out  32  read data, valid while ack_o is high
- wb_ack_o  out  1  normal termination
- wb_err_o  out  1  error termination (out-of-range word index)
- wb_rty_o  out  1  constant 0

Behaviour:
- Reset (rst_ni low, async):
  - FSM goes to IDLE; ack_o, err_o, rty_o and dat_o are 0; wait counter and burst address are cleared.
  - RAM contents are not reset.
  - Reset asserted mid-burst aborts the burst immediately; no further RAM write occurs.
- Request = cyc_i & stb_i. ack_o and err_o are registered flops additionally ANDed with the request, so they never appear outside a request.
- FSM states: IDLE, WAIT, ACK_CLASSIC, BURST.
- IDLE:
  - On request, latch the word index and wait count = WAIT_STATES.
  - Go to WAIT if WAIT_STATES > 0.
  - Otherwise go to ACK_CLASSIC (cti 000/111/other) or BURST (cti 010).
  - First ack therefore appears 1 + WAIT_STATES cycles after the request is sampled.
- WAIT: decrement per cycle; at 0, move to the same target as IDLE. Request dropping in WAIT returns to IDLE with no access.
- ACK_CLASSIC:
  - Assert ack_o (or err_o) for exactly one cycle.
  - A write commits on that edge, applying only enabled bytes.
  - Return to IDLE. A held strobe is then a new transfer, so classic throughput is 1 transfer per 2 cycles at WAIT_STATES=0.
- BURST:
  - Each cycle with request high: ack one beat, commit a write if we_i, and advance the internal word index.
  - Linear: index + 1, wrapping modulo MEM_WORDS.
  - wrapN: low log2(N) bits increment modulo N; upper bits are held.
  - Read data for the next beat is fetched from the predicted index so that acks are back-to-back.
  - Request low while cyc_i is high: hold state, no ack, index not advanced.
  - cti_i = 111 on an acked beat: final beat, then IDLE.
  - cyc_i low: go to IDLE immediately.
  - Wait states apply only before the first beat.
- Out-of-range index (>= MEM_WORDS, checked on every beat):
  - err_o is asserted instead of ack_o; writes are suppressed and dat_o = 0.
  - A burst continues beat by beat and is independently checked.
- Simultaneous termination of a burst with a new cycle: IDLE always samples afresh; there is no back-to-back cycle without an IDLE cycle between them.
- ack_o and err_o are never high together; rty_o is never asserted.

Test Plan:
- WAIT_STATES=0, classic write 0xDEADBEEF sel=1111 to 0x10, then classic read of 0x10 -> ack 1 cycle after each stb, read dat_o = 0xDEADBEEF, ack low in the cycle after each ack.
- Byte enables: write 0x11223344 sel=1111 then 0xAABBCCDD sel=0101 to 0x20 -> read returns 0x11BB33DD.
- Burst read cti=010 bte=01 start 0x0C over words preloaded with value = word index -> beats return 3,0,1,2 on 4 consecutive ack cycles; 4th beat sent with cti=111, FSM back in IDLE.
- WAIT_STATES=2 classic read -> ack exactly 3 cycles after stb sampled; stb dropped in 2nd wait cycle -> no ack, no err, IDLE.
- MEM_WORDS=4096, read address 0x4000 (word 4096) -> err_o for one cycle, ack_o 0, dat_o 0; write to the same address leaves RAM unchanged.
- Linear write burst of 8 beats, stb low for 2 cycles after beat 3 -> beats 4-8 land at consecutive words with no gap error; rst_ni pulsed low mid-burst -> ack_o 0 same cycle, later reads show only beats before reset written.

Source files
------------

// File: rtl/wb_ext_mem_responder_if.sv
// Wishbone B3 bus between the core's external memory port and the memory responder.
// Signal names are seen from the responder (slave) side.
interface wb_ext_mem_responder_if #(
    parameter int ADDR_WIDTH = 27,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   wb_adr_i;
    logic [DATA_WIDTH-1:0]   wb_dat_i;
    logic [DATA_WIDTH/8-1:0] wb_sel_i;
    logic                    wb_we_i;
    logic                    wb_cyc_i;
    logic                    wb_stb_i;
    logic [2:0]              wb_cti_i;
    logic [1:0]              wb_bte_i;
    logic [DATA_WIDTH-1:0]   wb_dat_o;
    logic                    wb_ack_o;
    logic                    wb_err_o;
    logic                    wb_rty_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );
endinterface

// File: rtl/wb_ext_mem_responder.sv
// Wishbone B3 memory responder behind the core's external memory port.
// Word-organised RAM, classic cycles plus registered-feedback incrementing
// bursts (linear, wrap4/8/16), optional wait states before the first beat and
// an error termination for word indices beyond the implemented depth.
module wb_ext_mem_responder #(
    parameter int ADDR_WIDTH  = 27,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_WORDS   = 4096,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    wb_ext_mem_responder_if.slave wb
);

    localparam int         IDX_W     = ADDR_WIDTH - 2;
    localparam int         MEM_AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int         SEL_W     = DATA_WIDTH / 8;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    localparam logic [2:0] CTI_INCR   = 3'b010;
    localparam logic [2:0] CTI_END    = 3'b111;
    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK_CLASSIC,
        S_BURST
    } state_e;

    state_e                state_q;
    logic                  ack_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] dat_q;
    logic [3:0]            wait_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  burst_q;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic                  req;
    logic [IDX_W-1:0]      req_idx;
    logic [1:0]            unused_adr_lsb;

    logic [IDX_W-1:0]      launch_idx;
    logic                  launch_burst;
    logic                  launch_ok;
    logic [DATA_WIDTH-1:0] launch_dat;

    logic [IDX_W-1:0]      wrap_mask;
    logic [IDX_W-1:0]      inc_idx;
    logic [IDX_W-1:0]      next_idx_d;
    logic                  next_ok;
    logic [DATA_WIDTH-1:0] next_dat;

    logic                  mem_we_d;

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return 64'(idx) < 64'(MEM_WORDS);
    endfunction

    assign req            = wb.wb_cyc_i & wb.wb_stb_i;
    assign req_idx        = wb.wb_adr_i[ADDR_WIDTH-1:2];
    assign unused_adr_lsb = wb.wb_adr_i[1:0];

    // First-beat source: the live bus when launching from IDLE, the latched request after wait states.
    // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
    always_comb begin
        launch_idx   = idx_q;
        launch_burst = burst_q;
        if (state_q == S_IDLE) begin
            launch_idx   = req_idx;
            launch_burst = (wb.wb_cti_i == CTI_INCR);
        end
    end

    assign launch_ok  = in_range(launch_idx);
    assign launch_dat = launch_ok ? mem[launch_idx[MEM_AW-1:0]] : '0;

    // Predicted index of the following burst beat, so its read data is ready on the next ack.
    always_comb begin
        wrap_mask = '0;
        case (wb.wb_bte_i)
            BTE_WRAP4:  wrap_mask = IDX_W'(3);
            BTE_WRAP8:  wrap_mask = IDX_W'(7);
            BTE_WRAP16: wrap_mask = IDX_W'(15);
            default:    wrap_mask = '0;
        endcase
        inc_idx = idx_q + IDX_W'(1);
        if (wb.wb_bte_i == BTE_LINEAR) begin
            next_idx_d = (idx_q == IDX_W'(MEM_WORDS - 1)) ? '0 : inc_idx;
        end else begin
            next_idx_d = (idx_q & ~wrap_mask) | (inc_idx & wrap_mask);
        end
    end

    assign next_ok  = in_range(next_idx_d);
    assign next_dat = next_ok ? mem[next_idx_d[MEM_AW-1:0]] : '0;

    // A write commits only on an acked beat; ack_q is never set for an out-of-range index.
    assign mem_we_d = ((state_q == S_ACK_CLASSIC) || (state_q == S_BURST))
                      && req && ack_q && wb.wb_we_i;

    // RAM write port: a committed beat updates only the enabled byte lanes.
    // NOTE: the RAM has no reset on purpose; its contents must survive rst_ni and a per-word clear would not map onto memory.
    always_ff @(posedge clk_i) begin
        if (mem_we_d) begin
            for (int b = 0; b < SEL_W; b++) begin
                if (wb.wb_sel_i[b]) begin
                    mem[idx_q[MEM_AW-1:0]][8*b +: 8] <= wb.wb_dat_i[8*b +: 8];
                end
            end
        end
    end

    // Bus protocol FSM; terminations and read data are registered here and qualified by the live request.
    // NOTE: state is updated with non-blocking assignments so every branch sees pre-edge values of the flops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
            wait_q  <= '0;
            idx_q   <= '0;
            burst_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                    dat_q <= '0;
                    if (req) begin
                        idx_q   <= req_idx;
                        burst_q <= launch_burst;
                        wait_q  <= WAIT_INIT;
                        if (WAIT_INIT != 4'd0) begin
                            state_q <= S_WAIT;
                        end else begin
                            state_q <= launch_burst ? S_BURST : S_ACK_CLASSIC;
                            ack_q   <= launch_ok;
                            err_q   <= !launch_ok;
                            dat_q   <= launch_dat;
                        end
                    end
                end

                S_WAIT: begin
                    if (!req) begin
                        // Master abandoned the request: no access is made.
                        state_q <= S_IDLE;
                    end else begin
                        wait_q <= wait_q - 4'd1;
                        if (wait_q <= 4'd1) begin
                            state_q <= launch_burst ? S_BURST : S_ACK_CLASSIC;
                            ack_q   <= launch_ok;
                            err_q   <= !launch_ok;
                            dat_q   <= launch_dat;
                        end
                    end
                end

                S_ACK_CLASSIC: begin
                    // Single termination cycle; a held strobe is sampled afresh from IDLE.
                    state_q <= S_IDLE;
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    dat_q   <= '0;
                end

                S_BURST: begin
                    if (!wb.wb_cyc_i || (req && (wb.wb_cti_i == CTI_END))) begin
                        state_q <= S_IDLE;
                        ack_q   <= 1'b0;
                        err_q   <= 1'b0;
                        dat_q   <= '0;
                    end else if (req) begin
                        // Beat terminated this cycle: move to the next word and prefetch it.
                        idx_q <= next_idx_d;
                        ack_q <= next_ok;
                        err_q <= !next_ok;
                        dat_q <= next_dat;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign wb.wb_ack_o = ack_q & req;
    assign wb.wb_err_o = err_q & req;
    assign wb.wb_dat_o = dat_q;
    assign wb.wb_rty_o = 1'b0;

endmodule
